axi_channel_dma: RTL and testbench
==================================

// Module: axi_channel_dma
// PURPOSE
//  Parametrised successor to the channel AXI front-end.
//  Contains an AXI4-Lite register file that drives a byte-granular DMA engine.
//  The engine moves COUNT bytes between memory and the channel data stream, in either direction.
//  Memory access goes through the byte-IO master handshake (axi_byte_io): start/done, one byte per access.
//  Completion and error are reported through sticky status bits and a level irq.
// PARAMETERS
//  S_ADDR_W  8   AXI-Lite address width; only bits [7:0] are decoded.
//  DMA_ADDR_W  32  memory byte-address width.
//  COUNT_W  16  transfer-length width in bytes.
// PORTS
//  aclk  in  1  clock, rising edge
//  aresetn  in  1  synchronous, active-low reset
//  s_axi_ar{valid,ready}/araddr[S_ADDR_W]  AXI-Lite read address
//  s_axi_r{valid,ready}/rdata[32]/rresp[2]  AXI-Lite read data
//  s_axi_aw{valid,ready}/awaddr[S_ADDR_W]  AXI-Lite write address
//  s_axi_w{valid,ready}/wdata[32]/wstrb[4]  AXI-Lite write data
//  s_axi_b{valid,ready}/bresp[2]  AXI-Lite write response
//  x_start  out  1  one-cycle request to byte-IO
//  x_write  out  1  1 = byte write to memory
//  x_addr  out  DMA_ADDR_W  byte address
//  x_data_write  out  8  byte to store
//  x_data_read  in  8  byte loaded; valid when x_done
//  x_done  in  1  one-cycle access-complete pulse
//  x_busy  in  1  byte-IO cannot accept x_start
//  tx_data/tx_valid/tx_ready  out/out/in  8/1/1  memory->channel byte stream
//  rx_data/rx_valid/rx_ready  in/in/out  8/1/1  channel->memory byte stream
//  irq  out  1  (done|error) & irq_en
// BEHAVIOUR
//  Reset outputs:
//  - arready = awready = wready = 1.
//  - rvalid, bvalid, rdata, resp = 0.
//  - x_start, tx_valid, rx_ready, irq = 0.
//  - All registers = 0. State IDLE.
//  AXI-Lite rules:
//  - One outstanding read; rvalid asserts the cycle after the AR handshake.
//  - arready is low while rvalid is high.
//  - AW and W are captured independently; each ready drops once its beat is captured.
//  - bvalid asserts the cycle after both beats are held.
//  - Both readies reassert on the B handshake.
//  - Unmapped addresses return SLVERR (2'b10). wstrb is ignored; full-word writes only.
//  Register map:
//  - 0x00 CTRL  W: [0] start pulse, [1] abort pulse, [2] dir (1 = mem->tx), [3] irq_en.
//    R: dir, irq_en, [0] reads busy.
//  - 0x04 STAT  R: [0] busy, [1] done, [2] error, [31:16] remaining count (zero-extended).
//    W: bit1 and bit2 are write-1-to-clear.
//  - 0x08 ADDR  R/W: start address. Writes while busy return SLVERR and the register is unchanged.
//  - 0x0C COUNT  R/W: byte count. Writes while busy return SLVERR and the register is unchanged.
//  - CTRL start while busy: SLVERR, ignored. Start also clears done and error.
//  FSM:
//  - IDLE: on start, latch cur_addr := ADDR and rem := COUNT.
//    rem == 0 -> FINISH; else dir ? RD_REQ : RX_WAIT.
//  - RD_REQ: wait for !x_busy, then pulse x_start with x_write = 0 -> RD_WAIT.
//  - RD_WAIT: on x_done, latch byte -> TX.
//  - TX: hold tx_valid with a stable byte until tx_ready -> ADV.
//  - RX_WAIT: rx_ready = 1; on rx_valid, latch byte -> WR_REQ.
//  - WR_REQ: wait for !x_busy, then pulse x_start with x_write = 1 -> WR_WAIT.
//  - WR_WAIT: on x_done -> ADV.
//  - ADV: cur_addr += 1 (wraps modulo 2^DMA_ADDR_W), rem -= 1.
//    rem becoming 0 -> FINISH; else back to RD_REQ or RX_WAIT.
//  - FINISH: set done -> IDLE. busy is high in every state except IDLE.
//  Abort:
//  - In RD_WAIT or WR_WAIT, complete the outstanding access first (wait for x_done).
//  - Otherwise act on the next cycle: drop tx_valid / rx_ready, set error (not done), go IDLE.
//  - rem keeps its residual value.
//  Simultaneous events:
//  - A W1C write in the same cycle as done/error being set leaves the bit set.
//  Mid-operation reset:
//  - aresetn low forces IDLE and the reset values above.
//  - Any in-flight byte-IO done is ignored.
//  irq is combinational from the registered status bits.
// TESTING
//  1. ADDR=0x100, COUNT=3, CTRL=0x5 (start, dir=1), memory 0xAA,0xBB,0xCC.
//     -> tx bytes AA,BB,CC; reads at 0x100-0x102; STAT=0x2; irq low.
//  2. dir=0, irq_en=1, COUNT=2, rx bytes 0x11,0x22.
//     -> byte writes 0x11 @ADDR, 0x22 @ADDR+1; done=1; irq=1.
//     -> STAT write 0x2 clears done and irq.
//  3. COUNT=0 with start.
//     -> no x_start pulse; done set within 3 cycles; busy never visible to a read after done.
//  4. dir=1, COUNT=4, tx_ready held low; abort after the first byte is in TX.
//     -> tx_valid drops; STAT error=1, done=0, remaining=4.
//  5. While busy: write ADDR, write CTRL start, read 0x10.
//     -> bresp=SLVERR, SLVERR, rresp=SLVERR; ADDR unchanged.
//  6. ADDR=0xFFFFFFFF, COUNT=2, dir=0.
//     -> writes to 0xFFFFFFFF then 0x00000000; aresetn low mid-transfer returns all outputs to reset values.

Source files
------------

// File: rtl/axi_channel_dma.sv
// AXI4-Lite register file driving a byte-granular DMA engine that moves bytes between
// memory (through the byte-IO start/done master handshake) and the channel byte streams.
module axi_channel_dma #(
    parameter int unsigned S_ADDR_W   = 8,
    parameter int unsigned DMA_ADDR_W = 32,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [S_ADDR_W-1:0]   s_axi_araddr,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [S_ADDR_W-1:0]   s_axi_awaddr,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp,
    output logic                  x_start,
    output logic                  x_write,
    output logic [DMA_ADDR_W-1:0] x_addr,
    output logic [7:0]            x_data_write,
    input  logic [7:0]            x_data_read,
    input  logic                  x_done,
    input  logic                  x_busy,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  irq
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [3:0] {
        IDLE, RD_REQ, RD_WAIT, TX, RX_WAIT, WR_REQ, WR_WAIT, ADV, FINISH
    } state_t;

    state_t                state;
    logic [DMA_ADDR_W-1:0] addr_reg, cur_addr;
    logic [COUNT_W-1:0]    count_reg, rem;
    logic                  dir, irq_en, done, error, abort_pend;
    logic                  aw_held, w_held;
    logic [7:0]            awaddr_q;
    logic [31:0]           wdata_q;

    logic                  busy_c, wr_fire_c, wr_err_c, rd_err_c;
    logic [31:0]           rd_data_c;
    logic                  unused_ok;

    assign busy_c    = (state != IDLE);
    assign wr_fire_c = aw_held && w_held && !s_axi_bvalid;
    assign irq       = (done | error) & irq_en;
    assign unused_ok = &{1'b0, s_axi_wstrb, s_axi_araddr, s_axi_awaddr, wdata_q};

    // Read decode, evaluated on the AR handshake
    always_comb begin
        rd_data_c = '0;
        rd_err_c  = 1'b0;
        case (s_axi_araddr[7:0])
            8'h00:   rd_data_c = {28'd0, irq_en, dir, 1'b0, busy_c};
            8'h04:   rd_data_c = {16'(rem), 13'd0, error, done, busy_c};
            8'h08:   rd_data_c = 32'(addr_reg);
            8'h0C:   rd_data_c = 32'(count_reg);
            default: rd_err_c  = 1'b1;
        endcase
    end

    // Write error: start while busy, ADDR/COUNT while busy, unmapped
    always_comb begin
        wr_err_c = 1'b0;
        case (awaddr_q)
            8'h00:        wr_err_c = busy_c && wdata_q[0];
            8'h04:        wr_err_c = 1'b0;
            8'h08, 8'h0C: wr_err_c = busy_c;
            default:      wr_err_c = 1'b1;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= IDLE;
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            x_start       <= 1'b0;
            x_write       <= 1'b0;
            x_addr        <= '0;
            x_data_write  <= '0;
            tx_data       <= '0;
            tx_valid      <= 1'b0;
            rx_ready      <= 1'b0;
            addr_reg      <= '0;
            cur_addr      <= '0;
            count_reg     <= '0;
            rem           <= '0;
            dir           <= 1'b0;
            irq_en        <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            abort_pend    <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
        end else begin
            x_start <= 1'b0;

            if (s_axi_arvalid && s_axi_arready) begin
                s_axi_rvalid  <= 1'b1;
                s_axi_arready <= 1'b0;
                s_axi_rdata   <= rd_data_c;
                s_axi_rresp   <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid  <= 1'b0;
                s_axi_arready <= 1'b1;
            end

            if (s_axi_awvalid && s_axi_awready) begin
                awaddr_q      <= s_axi_awaddr[7:0];
                aw_held       <= 1'b1;
                s_axi_awready <= 1'b0;
            end
            if (s_axi_wvalid && s_axi_wready) begin
                wdata_q      <= s_axi_wdata;
                w_held       <= 1'b1;
                s_axi_wready <= 1'b0;
            end
            if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid  <= 1'b0;
                aw_held       <= 1'b0;
                w_held        <= 1'b0;
                s_axi_awready <= 1'b1;
                s_axi_wready  <= 1'b1;
            end

            // W1C sits ahead of the engine so a same-cycle set wins
            if (wr_fire_c && awaddr_q == 8'h04) begin
                if (wdata_q[1]) done  <= 1'b0;
                if (wdata_q[2]) error <= 1'b0;
            end

            case (state)
                IDLE: abort_pend <= 1'b0;
                RD_REQ, TX, RX_WAIT, WR_REQ, ADV: begin
                    if (abort_pend) begin
                        error      <= 1'b1;
                        tx_valid   <= 1'b0;
                        rx_ready   <= 1'b0;
                        abort_pend <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        case (state)
                            RD_REQ, WR_REQ: begin
                                if (!x_busy) begin
                                    x_start <= 1'b1;
                                    x_write <= (state == WR_REQ);
                                    x_addr  <= cur_addr;
                                    state   <= (state == WR_REQ) ? WR_WAIT : RD_WAIT;
                                end
                            end
                            TX: begin
                                if (tx_ready) begin
                                    tx_valid <= 1'b0;
                                    state    <= ADV;
                                end
                            end
                            RX_WAIT: begin
                                if (rx_valid) begin
                                    x_data_write <= rx_data;
                                    rx_ready     <= 1'b0;
                                    state        <= WR_REQ;
                                end
                            end
                            default: begin
                                cur_addr <= cur_addr + DMA_ADDR_W'(1);
                                rem      <= rem - COUNT_W'(1);
                                if (rem == COUNT_W'(1)) begin
                                    state <= FINISH;
                                end else if (dir) begin
                                    state <= RD_REQ;
                                end else begin
                                    rx_ready <= 1'b1;
                                    state    <= RX_WAIT;
                                end
                            end
                        endcase
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    // An abort waits for the outstanding access to complete
                    if (x_done) begin
                        if (abort_pend) begin
                            error      <= 1'b1;
                            abort_pend <= 1'b0;
                            state      <= IDLE;
                        end else if (state == RD_WAIT) begin
                            tx_data  <= x_data_read;
                            tx_valid <= 1'b1;
                            state    <= TX;
                        end else begin
                            state <= ADV;
                        end
                    end
                end
                FINISH: begin
                    done       <= 1'b1;
                    abort_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Register writes; start is only accepted from IDLE
            if (wr_fire_c) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_err_c ? RESP_SLVERR : RESP_OKAY;
                case (awaddr_q)
                    8'h00: begin
                        irq_en <= wdata_q[3];
                        if (!busy_c) begin
                            dir <= wdata_q[2];
                            if (wdata_q[0]) begin
                                cur_addr   <= addr_reg;
                                rem        <= count_reg;
                                done       <= 1'b0;
                                error      <= 1'b0;
                                abort_pend <= 1'b0;
                                if (count_reg == '0) begin
                                    state <= FINISH;
                                end else if (wdata_q[2]) begin
                                    state <= RD_REQ;
                                end else begin
                                    rx_ready <= 1'b1;
                                    state    <= RX_WAIT;
                                end
                            end
                        end else if (wdata_q[1]) begin
                            abort_pend <= 1'b1;
                        end
                    end
                    8'h08: if (!busy_c) addr_reg <= DMA_ADDR_W'(wdata_q);
                    8'h0C: if (!busy_c) count_reg <= COUNT_W'(wdata_q);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_channel_dma.sv
// Directed bench for axi_channel_dma: byte-IO memory model, tx sink, rx source, AXI-Lite tasks.
module tb_axi_channel_dma;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_axi_arvalid = 1'b0, s_axi_arready;
    logic [7:0]  s_axi_araddr = '0;
    logic        s_axi_rvalid, s_axi_rready = 1'b0;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_awvalid = 1'b0, s_axi_awready;
    logic [7:0]  s_axi_awaddr = '0;
    logic        s_axi_wvalid = 1'b0, s_axi_wready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = 4'hF;
    logic        s_axi_bvalid, s_axi_bready = 1'b0;
    logic [1:0]  s_axi_bresp;
    logic        x_start, x_write;
    logic [31:0] x_addr;
    logic [7:0]  x_data_write;
    logic [7:0]  x_data_read = '0;
    logic        x_done = 1'b0, x_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0, rx_ready;
    logic        irq;

    int errors = 0;
    int checks = 0;
    int lat = 2;

    logic [7:0]  mem [logic [31:0]];
    logic [31:0] acc_addr [$];
    logic        acc_wr [$];
    logic [7:0]  acc_data [$];
    logic [7:0]  tx_q [$];
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    logic        pend_wr = 1'b0;

    axi_channel_dma #(.S_ADDR_W(8), .DMA_ADDR_W(32), .COUNT_W(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .x_start(x_start), .x_write(x_write), .x_addr(x_addr), .x_data_write(x_data_write),
        .x_data_read(x_data_read), .x_done(x_done), .x_busy(x_busy),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .irq(irq)
    );

    always #5 aclk = ~aclk;

    // Byte-IO memory with 'lat' cycles of latency; deliberately not reset, so a done can land after a reset
    always @(negedge aclk) begin
        x_done = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                x_done = 1'b1;
                x_busy = 1'b0;
                x_data_read = (!pend_wr && mem.exists(pend_addr)) ? mem[pend_addr] : 8'h00;
            end
        end
        if (x_start) begin
            acc_addr.push_back(x_addr);
            acc_wr.push_back(x_write);
            acc_data.push_back(x_data_write);
            pend_cnt  = lat;
            pend_addr = x_addr;
            pend_wr   = x_write;
            x_busy    = 1'b1;
            if (x_write) mem[x_addr] = x_data_write;
        end
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    end

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, output logic [1:0] resp);
        int n;
        bit aw_done, w_done, ah, wh;
        @(posedge aclk); #1;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge aclk);
            ah = s_axi_awvalid && s_axi_awready;
            wh = s_axi_wvalid && s_axi_wready;
            @(posedge aclk); #1;
            if (ah) begin s_axi_awvalid = 1'b0; aw_done = 1; end
            if (wh) begin s_axi_wvalid = 1'b0; w_done = 1; end
            n++;
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1; n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi_bvalid && n < 20);
        resp = s_axi_bresp;
        if (!(aw_done && w_done && s_axi_bvalid)) begin
            checks++; errors++;
            $display("FAIL axi_write timeout addr=%h", a);
            resp = 2'bxx;
        end
        @(posedge aclk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        bit ok;
        @(posedge aclk); #1;
        s_axi_araddr = a; s_axi_arvalid = 1'b1; n = 0; ok = 0;
        do begin @(negedge aclk); n++; end while (!s_axi_arready && n < 20);
        ok = s_axi_arready;
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b1; n = 0;
        do begin @(negedge aclk); n++; end while (!s_axi_rvalid && n < 20);
        d = s_axi_rdata; resp = s_axi_rresp;
        if (!(ok && s_axi_rvalid)) begin
            checks++; errors++;
            $display("FAIL axi_read timeout addr=%h", a);
            d = 'x;
        end
        @(posedge aclk); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b);
        int n;
        @(posedge aclk); #1;
        rx_data = b; rx_valid = 1'b1; n = 0;
        do begin @(negedge aclk); n++; end while (!rx_ready && n < 50);
        if (!rx_ready) begin
            checks++; errors++;
            $display("FAIL rx_send timeout byte=%h", b);
        end
        @(posedge aclk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic [31:0] d;
        logic [1:0]  r;
        int n = 0;
        do begin axi_read(8'h04, d, r); n++; end while (d[0] !== 1'b0 && n < 60);
        if (d[0] !== 1'b0) begin
            checks++; errors++;
            $display("FAIL wait_idle timeout stat=%h", d);
        end
    endtask

    task automatic do_reset();
        @(posedge aclk); #1;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    task automatic clear_logs();
        acc_addr.delete(); acc_wr.delete(); acc_data.delete(); tx_q.delete();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        do_reset();
        @(negedge aclk);
        checks++;
        if ({s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_bvalid,
             x_start, tx_valid, rx_ready, irq} !== 9'b111_000000) begin
            errors++;
            $display("FAIL reset_outputs got=%b expected=111000000",
                     {s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_bvalid,
                      x_start, tx_valid, rx_ready, irq});
        end
        checks++;
        if ({s_axi_rdata, s_axi_rresp, s_axi_bresp} !== 36'd0) begin
            errors++; $display("FAIL reset_data rdata=%h rresp=%b bresp=%b", s_axi_rdata, s_axi_rresp, s_axi_bresp);
        end
        axi_read(8'h04, d, r);
        checks++;
        if ({d, r} !== {32'h0, 2'b00}) begin errors++; $display("FAIL reset_stat got=%h/%b expected=0/00", d, r); end
        axi_read(8'h0C, d, r);
        checks++;
        if ({d, r} !== {32'h0, 2'b00}) begin errors++; $display("FAIL reset_count got=%h/%b expected=0/00", d, r); end
    endtask

    task automatic test_mem_to_tx();
        logic [31:0] d;
        logic [1:0]  r1, r2, r3, r;
        logic [23:0] got;
        clear_logs();
        mem[32'h100] = 8'hAA; mem[32'h101] = 8'hBB; mem[32'h102] = 8'hCC;
        tx_ready = 1'b1;
        axi_write(8'h08, 32'h100, r1);
        axi_write(8'h0C, 32'd3, r2);
        axi_write(8'h00, 32'h5, r3);
        checks++;
        if ({r1, r2, r3} !== 6'b0) begin errors++; $display("FAIL tx_setup_bresp got=%b%b%b expected=000000", r1, r2, r3); end
        wait_idle();
        got = (tx_q.size() == 3) ? {tx_q[0], tx_q[1], tx_q[2]} : 24'hxxxxxx;
        checks++;
        if (got !== 24'hAABBCC) begin errors++; $display("FAIL tx_bytes got=%h (n=%0d) expected=aabbcc", got, tx_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= acc_addr.size() || acc_addr[i] !== 32'h100 + 32'(i) || acc_wr[i] !== 1'b0) begin
                errors++; $display("FAIL tx_read_access idx=%0d n=%0d expected read at %h", i, acc_addr.size(), 32'h100 + 32'(i));
            end
        end
        checks++;
        if (acc_addr.size() != 3) begin errors++; $display("FAIL tx_access_count got=%0d expected=3", acc_addr.size()); end
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL tx_stat got=%h expected=00000002", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL tx_irq got=%b expected=0", irq); end
    endtask

    task automatic test_rx_to_mem();
        logic [31:0] d;
        logic [1:0]  r;
        clear_logs();
        axi_write(8'h08, 32'h200, r);
        axi_write(8'h0C, 32'd2, r);
        axi_write(8'h00, 32'h9, r);
        rx_send(8'h11);
        rx_send(8'h22);
        wait_idle();
        checks++;
        if (acc_addr.size() != 2 || acc_addr[0] !== 32'h200 || acc_wr[0] !== 1'b1 || acc_data[0] !== 8'h11) begin
            errors++; $display("FAIL rx_write0 n=%0d expected write 11 @00000200", acc_addr.size());
        end
        checks++;
        if (acc_addr.size() != 2 || acc_addr[1] !== 32'h201 || acc_wr[1] !== 1'b1 || acc_data[1] !== 8'h22) begin
            errors++; $display("FAIL rx_write1 n=%0d expected write 22 @00000201", acc_addr.size());
        end
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL rx_stat got=%h expected=00000002", d); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq_set got=%b expected=1", irq); end
        axi_write(8'h04, 32'h2, r);
        @(negedge aclk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_clear got=%b expected=0", irq); end
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rx_stat_clear got=%h expected=00000000", d); end
        axi_read(8'h00, d, r);
        checks++;
        if (d !== 32'h8) begin errors++; $display("FAIL rx_ctrl_read got=%h expected=00000008", d); end
    endtask

    task automatic test_zero_count();
        logic [31:0] d;
        logic [1:0]  r;
        clear_logs();
        axi_write(8'h0C, 32'd0, r);
        axi_write(8'h00, 32'h1, r);
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL zero_stat got=%h expected=00000002", d); end
        repeat (5) @(negedge aclk);
        checks++;
        if (acc_addr.size() != 0) begin errors++; $display("FAIL zero_no_access got=%0d expected=0", acc_addr.size()); end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        logic [1:0]  r;
        int n = 0;
        clear_logs();
        mem[32'h300] = 8'h31; mem[32'h301] = 8'h32; mem[32'h302] = 8'h33; mem[32'h303] = 8'h34;
        tx_ready = 1'b0;
        axi_write(8'h08, 32'h300, r);
        axi_write(8'h0C, 32'd4, r);
        axi_write(8'h00, 32'h5, r);
        do begin @(negedge aclk); n++; end while (!tx_valid && n < 40);
        checks++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h31}) begin errors++; $display("FAIL abort_tx_hold got=%b/%h expected=1/31", tx_valid, tx_data); end
        axi_write(8'h00, 32'h2, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL abort_bresp got=%b expected=00", r); end
        repeat (3) @(negedge aclk);
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL abort_tx_drop got=%b expected=0", tx_valid); end
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h0004_0004) begin errors++; $display("FAIL abort_stat got=%h expected=00040004", d); end
        checks++;
        if (tx_q.size() != 0 || acc_addr.size() != 1) begin
            errors++; $display("FAIL abort_traffic tx=%0d acc=%0d expected=0/1", tx_q.size(), acc_addr.size());
        end
        axi_write(8'h04, 32'h4, r);
        tx_ready = 1'b1;
    endtask

    task automatic test_busy_errors();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(8'h08, 32'h400, r);
        axi_write(8'h0C, 32'd5, r);
        axi_write(8'h00, 32'h1, r);
        repeat (2) @(negedge aclk);
        checks++;
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL busy_rx_ready got=%b expected=1", rx_ready); end
        axi_write(8'h08, 32'h999, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL busy_addr_bresp got=%b expected=10", r); end
        axi_write(8'h00, 32'h1, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL busy_start_bresp got=%b expected=10", r); end
        axi_write(8'h0C, 32'd7, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL busy_count_bresp got=%b expected=10", r); end
        axi_read(8'h10, d, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL unmapped_rresp got=%b expected=10", r); end
        axi_read(8'h08, d, r);
        checks++;
        if ({d, r} !== {32'h400, 2'b00}) begin errors++; $display("FAIL busy_addr_kept got=%h/%b expected=00000400/00", d, r); end
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h0005_0001) begin errors++; $display("FAIL busy_stat got=%h expected=00050001", d); end
        axi_write(8'h00, 32'h2, r);
        repeat (3) @(negedge aclk);
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h0005_0004) begin errors++; $display("FAIL rx_abort_stat got=%h expected=00050004", d); end
        axi_read(8'h0C, d, r);
        checks++;
        if (d !== 32'd5) begin errors++; $display("FAIL busy_count_kept got=%h expected=00000005", d); end
        axi_write(8'h04, 32'h4, r);
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] d;
        logic [1:0]  r;
        int n, n0;
        clear_logs();
        axi_write(8'h08, 32'hFFFF_FFFF, r);
        axi_write(8'h0C, 32'd2, r);
        axi_write(8'h00, 32'h1, r);
        rx_send(8'hA1);
        rx_send(8'hA2);
        wait_idle();
        checks++;
        if (acc_addr.size() != 2 || acc_addr[0] !== 32'hFFFF_FFFF || acc_wr[0] !== 1'b1 || acc_data[0] !== 8'hA1) begin
            errors++; $display("FAIL wrap_write0 n=%0d expected write a1 @ffffffff", acc_addr.size());
        end
        checks++;
        if (acc_addr.size() != 2 || acc_addr[1] !== 32'h0 || acc_wr[1] !== 1'b1 || acc_data[1] !== 8'hA2) begin
            errors++; $display("FAIL wrap_write1 n=%0d expected write a2 @00000000", acc_addr.size());
        end
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL wrap_stat got=%h expected=00000002", d); end

        lat = 6;
        axi_write(8'h08, 32'h10, r);
        axi_write(8'h0C, 32'd3, r);
        axi_write(8'h00, 32'h9, r);
        n0 = acc_addr.size();
        rx_send(8'h55);
        n = 0;
        do begin @(negedge aclk); n++; end while (acc_addr.size() == n0 && n < 20);
        do_reset();
        @(negedge aclk);
        checks++;
        if ({s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_bvalid,
             x_start, tx_valid, rx_ready, irq} !== 9'b111_000000) begin
            errors++;
            $display("FAIL midreset_outputs got=%b expected=111000000",
                     {s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_bvalid,
                      x_start, tx_valid, rx_ready, irq});
        end
        n0 = acc_addr.size();
        repeat (10) @(negedge aclk);
        checks++;
        if (acc_addr.size() != n0 || irq !== 1'b0) begin
            errors++; $display("FAIL midreset_quiet new_access=%0d irq=%b expected=0/0", acc_addr.size() - n0, irq);
        end
        axi_read(8'h04, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL midreset_stat got=%h expected=00000000", d); end
        axi_read(8'h08, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL midreset_addr got=%h expected=00000000", d); end
        axi_read(8'h00, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL midreset_ctrl got=%h expected=00000000", d); end
        lat = 2;
    endtask

    initial begin
        test_reset();
        test_mem_to_tx();
        test_rx_to_mem();
        test_zero_count();
        test_abort();
        test_busy_errors();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
